transpose_regbank: RTL and testbench

//   Parametrised N x N register bank that transposes data between the row and column passes of the 2D DCT.

---
 rtl/transpose_regbank.sv | 171 +++++++++++++++++
 tb/tb_transpose_regbank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_regbank.sv
// transpose_regbank
//   N x N coefficient transpose buffer between the row and column 1D-DCT
//   passes. Words are written row-major and read column-major, with
//   valid/ready handshakes on both sides.
//
//   Configuration macro: TRANSPOSE_PINGPONG_EN
//     defined   : two banks, so a new block streams in while the previous
//                 block streams out.
//     undefined : one bank. The write side stalls from the end of a block
//                 until that block has been fully read. Ports are identical.
//
//   All outputs are driven from flops. Each output register is loaded with
//   the next-state view of the bank, so the outputs always match the
//   current full flags and read pointer.
module transpose_regbank #(
    parameter int WIDTH = 16,
    parameter int N     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    localparam int DEPTH = N * N;
    localparam int CW    = $clog2(DEPTH);
    localparam int HW    = $clog2(N);
`ifdef TRANSPOSE_PINGPONG_EN
    localparam int AW    = CW + 1;
`else
    localparam int AW    = CW;
`endif
    localparam int SLOTS = 1 << AW;
    localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

    // Storage: one or two banks, each row-major within its slot range.
    logic [WIDTH-1:0] mem_r [SLOTS];

    logic [CW-1:0]    wr_cnt_r;
    logic [CW-1:0]    rd_cnt_r;
    logic             wr_bank_r;
    logic             rd_bank_r;
    logic [1:0]       full_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [WIDTH-1:0] out_data_r;

    logic             wr_fire_s;
    logic             wr_wrap_s;
    logic             rd_fire_s;
    logic             rd_wrap_s;
    logic [CW-1:0]    wr_cnt_nxt_s;
    logic [CW-1:0]    rd_cnt_nxt_s;
    logic             wr_bank_nxt_s;
    logic             rd_bank_nxt_s;
    logic [1:0]       full_nxt_s;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    rd_addr_nxt_s;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;
    logic             out_last_nxt_s;
    logic [WIDTH-1:0] out_data_nxt_s;

    // Next-state computation for pointers, full flags and output registers.
    always_comb begin
        wr_fire_s = in_valid & in_ready_r;
        wr_wrap_s = wr_fire_s & (wr_cnt_r == LAST_IDX);
        rd_fire_s = out_valid_r & out_ready;
        rd_wrap_s = rd_fire_s & out_last_r;

        // Counters are exactly log2(N*N) bits, so the increment wraps to 0.
        if (wr_fire_s) begin
            wr_cnt_nxt_s = wr_cnt_r + CW'(1);
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        if (rd_fire_s) begin
            rd_cnt_nxt_s = rd_cnt_r + CW'(1);
        end else begin
            rd_cnt_nxt_s = rd_cnt_r;
        end

`ifdef TRANSPOSE_PINGPONG_EN
        wr_bank_nxt_s = wr_bank_r ^ wr_wrap_s;
        rd_bank_nxt_s = rd_bank_r ^ rd_wrap_s;
`else
        wr_bank_nxt_s = 1'b0;
        rd_bank_nxt_s = 1'b0;
`endif

        // Set and clear always hit different banks, so both may apply.
        full_nxt_s = full_r;
        if (wr_wrap_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
        end else begin
            full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
        end
        if (rd_wrap_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
        end else begin
            full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
        end

        // Read address swaps row and column fields: entry [rd%N][rd/N].
`ifdef TRANSPOSE_PINGPONG_EN
        wr_addr_s     = {wr_bank_r, wr_cnt_r};
        rd_addr_nxt_s = {rd_bank_nxt_s, rd_cnt_nxt_s[HW-1:0], rd_cnt_nxt_s[CW-1:HW]};
`else
        wr_addr_s     = wr_cnt_r;
        rd_addr_nxt_s = {rd_cnt_nxt_s[HW-1:0], rd_cnt_nxt_s[CW-1:HW]};
`endif

        in_ready_nxt_s  = ~full_nxt_s[wr_bank_nxt_s];
        out_valid_nxt_s = full_nxt_s[rd_bank_nxt_s];
        out_last_nxt_s  = out_valid_nxt_s & (rd_cnt_nxt_s == LAST_IDX);

        // Bypass covers a slot that is being written on the same edge.
        if (!out_valid_nxt_s) begin
            out_data_nxt_s = {WIDTH{1'b0}};
        end else if (wr_fire_s && (wr_addr_s == rd_addr_nxt_s)) begin
            out_data_nxt_s = in_data;
        end else begin
            out_data_nxt_s = mem_r[rd_addr_nxt_s];
        end
    end

    // Storage write port; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_fire_s && !rst) begin
            mem_r[wr_addr_s] <= in_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r    <= {CW{1'b0}};
            rd_cnt_r    <= {CW{1'b0}};
            wr_bank_r   <= 1'b0;
            rd_bank_r   <= 1'b0;
            full_r      <= 2'b00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else begin
            wr_cnt_r    <= wr_cnt_nxt_s;
            rd_cnt_r    <= rd_cnt_nxt_s;
            wr_bank_r   <= wr_bank_nxt_s;
            rd_bank_r   <= rd_bank_nxt_s;
            full_r      <= full_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_last_r  <= out_last_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_transpose_regbank.sv
// Bench for transpose_regbank: N=8/WIDTH=16 instance plus an N=4/WIDTH=12
// instance. Expected transposed words are queued when a block is driven and
// compared as the DUT presents them. Honours TRANSPOSE_PINGPONG_EN.
module tb_transpose_regbank;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [11:0] b_in_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [11:0] b_out_data;
    logic        b_out_last;

    int vectors = 0;
    int errors  = 0;

    logic [16:0] exp_q[$];
    logic [12:0] b_exp_q[$];

    bit bp_mode   = 1'b0;
    bit gap_track = 1'b0;
    bit started   = 1'b0;
    bit expect_idle = 1'b0;
    bit wr_done   = 1'b0;
    bit b_done    = 1'b0;
    int gaps      = 0;
    int bp_phase  = 0;

    transpose_regbank #(.WIDTH(16), .N(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    transpose_regbank #(.WIDTH(12), .N(4)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Queue the column-major view of an 8x8 block starting at base.
    task automatic push_block(input int base);
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                exp_q.push_back({((r == 7) && (c == 7)) ? 1'b1 : 1'b0, 16'(base + r * 8 + c)});
            end
        end
    endtask

    // Drive n consecutive words starting at base; called and returns at a negedge.
    task automatic write_block(input int base, input int n, input bit push, output int stalls);
        int g;
        stalls = 0;
        if (push) push_block(base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(base + i);
            g = 0;
            while (!in_ready && g < 2000) begin
                @(negedge clk);
                stalls++;
                g++;
            end
            if (g >= 2000) check_eq("wr_timeout", 32'd0, 32'd1);
            if (i == n - 1) wr_done = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) check_eq({tag, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Consumer model for the 8x8 instance: sets out_ready, then checks output.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bp_mode) begin
                    out_ready = (bp_phase == 0) || (bp_phase == 3);
                    bp_phase  = (bp_phase + 1) % 4;
                end else begin
                    out_ready = 1'b1;
                end
                if (expect_idle && !wr_done) check_eq("t5_no_stale_valid", 32'(out_valid), 32'd0);
                if (gap_track) begin
                    if (out_valid) started = 1'b1;
                    else if (started && exp_q.size() > 0) gaps++;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_word", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("out_data", 32'(out_data), 32'(exp_q[0][15:0]));
                        check_eq("out_last", 32'(out_last), 32'(exp_q[0][16]));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check_eq("out_last_idle", 32'(out_last), 32'd0);
                end
            end
        end
    end

    // Producer and consumer for the 4x4, 12-bit instance.
    initial begin
        int g;
        b_in_valid  = 1'b0;
        b_in_data   = 12'd0;
        b_out_ready = 1'b1;
        @(negedge clk);
        while (rst) @(negedge clk);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b_exp_q.push_back({((r == 3) && (c == 3)) ? 1'b1 : 1'b0, 12'(r * 4 + c)});
        for (int i = 0; i < 16; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 12'(i);
            g = 0;
            while (!b_in_ready && g < 200) begin
                @(negedge clk);
                g++;
            end
            if (g >= 200) check_eq("b_wr_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check_eq("t6_first_valid", 32'(b_out_valid), 32'd1);
        b_done = 1'b1;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && b_out_valid) begin
                if (b_exp_q.size() == 0) begin
                    check_eq("b_spurious_word", 32'(b_out_data), 32'hFFFF_FFFF);
                end else begin
                    check_eq("b_out_data", 32'(b_out_data), 32'(b_exp_q[0][11:0]));
                    check_eq("b_out_last", 32'(b_out_last), 32'(b_exp_q[0][12]));
                    void'(b_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, %0d words outstanding", exp_q.size());
        errors++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int g;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready",  32'(in_ready),   32'd1);
        check_eq("rst_out_valid", 32'(out_valid),  32'd0);
        check_eq("rst_out_last",  32'(out_last),   32'd0);
        check_eq("rst_out_data",  32'(out_data),   32'd0);
        check_eq("rst_b_ready",   32'(b_in_ready), 32'd1);
        check_eq("rst_b_valid",   32'(b_out_valid), 32'd0);
        rst = 1'b0;

        // One block, continuous read: first word one cycle after the last write.
        write_block(0, 64, 1'b1, st);
        check_eq("t1_first_valid", 32'(out_valid), 32'd1);
        check_eq("t1_stalls", 32'(st), 32'd0);
        drain("t1");

`ifdef TRANSPOSE_PINGPONG_EN
        // Three back-to-back blocks stream with no input stall and no output gap.
        gaps = 0;
        started = 1'b0;
        gap_track = 1'b1;
        write_block(0, 64, 1'b1, st);
        check_eq("t2_stall_blk0", 32'(st), 32'd0);
        write_block(100, 64, 1'b1, st);
        check_eq("t2_stall_blk1", 32'(st), 32'd0);
        write_block(200, 64, 1'b1, st);
        check_eq("t2_stall_blk2", 32'(st), 32'd0);
        drain("t2");
        gap_track = 1'b0;
        check_eq("t2_output_gaps", 32'(gaps), 32'd0);
`else
        // Single bank: the second block waits exactly one block read time.
        write_block(0, 64, 1'b1, st);
        check_eq("t3_stall_blk0", 32'(st), 32'd0);
        write_block(100, 64, 1'b1, st);
        check_eq("t3_stall_blk1", 32'(st), 32'd64);
        drain("t3");
`endif

        // Backpressure 1,0,0,1 on the read side; writes must eventually stall.
        bp_phase = 0;
        bp_mode  = 1'b1;
        write_block(0, 64, 1'b1, st);
        write_block(1000, 64, 1'b1, st);
`ifdef TRANSPOSE_PINGPONG_EN
        write_block(2000, 64, 1'b1, st);
`endif
        check_eq("t4_full_stall", 32'(st > 0), 32'd1);
        drain("t4");
        bp_mode = 1'b0;

        g = 0;
        while (!b_done && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check_eq("t6_done", 32'(b_done), 32'd1);
        check_eq("t6_queue_empty", 32'(b_exp_q.size()), 32'd0);

        // Reset after 20 words of a block; that partial block must never appear.
        write_block(300, 20, 1'b0, st);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_rst_out_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        wr_done = 1'b0;
        expect_idle = 1'b1;
        write_block(500, 64, 1'b1, st);
        expect_idle = 1'b0;
        check_eq("t5_first_valid", 32'(out_valid), 32'd1);
        check_eq("t5_first_word",  32'(out_data),  32'd500);
        drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
